// File: rtl/logicnets_pkg.sv
// Shared types and default widths for the LogicNets inter-layer pipe.
// Imported by logicnets_skid_reg and logicnets_layer_pipe.
package logicnets_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } pipe_state_e;

   localparam int LN_SEQ_W = 8;
   localparam int LN_CNT_W = 16;

endpackage

// File: rtl/logicnets_skid_reg.sv
// Two-entry skid buffer with EMPTY/ONE/FULL FSM; outputs decode registers only.
// The main register feeds the output, the skid register absorbs one stall.
module logicnets_skid_reg
   import logicnets_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush_i,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [W-1:0] in_data_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] out_data_o
);

   pipe_state_e  state_q, state_d;
   logic [W-1:0] main_q, main_d;
   logic [W-1:0] skid_q, skid_d;
   logic         in_fire, out_fire;

   assign out_valid_o = (state_q != EMPTY);
   assign in_ready_o  = (state_q != FULL);
   assign out_data_o  = main_q;

   assign in_fire  = in_valid_i & in_ready_o;
   assign out_fire = out_valid_o & out_ready_i;

   // Next state and buffer loads; flush overrides any fire.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush_i) begin
         state_d = EMPTY;
         main_d  = '0;
         skid_d  = '0;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  main_d  = in_data_i;
                  state_d = ONE;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_d = in_data_i;
               end else if (in_fire) begin
                  skid_d  = in_data_i;
                  state_d = FULL;
               end else if (out_fire) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (out_fire) begin
                  main_d  = skid_q;
                  state_d = ONE;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   // State and payload registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

endmodule

// File: rtl/logicnets_layer_pipe.sv
// Registered valid/ready stage between LogicNets layers with sequence tags.
// Optional stall counter port enabled by LOGICNETS_STALL_CNT_EN.
module logicnets_layer_pipe
   import logicnets_pkg::*;
#(
   parameter int NEURONS = 8,
   parameter int SEQ_W   = LN_SEQ_W,
   parameter int CNT_W   = LN_CNT_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [NEURONS-1:0] in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [NEURONS-1:0] out_data,
   output logic [SEQ_W-1:0]   out_seq
`ifdef LOGICNETS_STALL_CNT_EN
   ,
   output logic [CNT_W-1:0]   stall_cnt
`endif
);

   localparam int PW = NEURONS + SEQ_W;

   logic [SEQ_W-1:0] seq_ctr_q, seq_ctr_d;
   logic [PW-1:0]    pay_in, pay_out;

   assign pay_in   = {seq_ctr_q, in_data};
   assign out_data = pay_out[NEURONS-1:0];
   assign out_seq  = pay_out[PW-1:NEURONS];

   logicnets_skid_reg #(.W(PW)) u_skid (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush_i    (flush),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready),
      .in_data_i  (pay_in),
      .out_valid_o(out_valid),
      .out_ready_i(out_ready),
      .out_data_o (pay_out)
   );

   // Tag counter advances on each accepted vector, wraps naturally.
   always_comb begin
      seq_ctr_d = seq_ctr_q;
      if (flush) begin
         seq_ctr_d = '0;
      end else if (in_valid && in_ready) begin
         seq_ctr_d = seq_ctr_q + 1'b1;
      end
   end

   // Tag counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seq_ctr_q <= '0;
      end else begin
         seq_ctr_q <= seq_ctr_d;
      end
   end

`ifdef LOGICNETS_STALL_CNT_EN
   logic [CNT_W-1:0] stall_q, stall_d;

   assign stall_cnt = stall_q;

   // Saturating count of cycles where output is held against backpressure.
   always_comb begin
      stall_d = stall_q;
      if (flush) begin
         stall_d = '0;
      end else if (out_valid && !out_ready && !(&stall_q)) begin
         stall_d = stall_q + 1'b1;
      end
   end

   // Stall counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end
`endif

endmodule

// File: tb/tb_logicnets_layer_pipe.sv
// Self-checking bench for logicnets_layer_pipe: tables, corner sequences,
// and randomized traffic against a FIFO-level reference model.
module tb_logicnets_layer_pipe;

   logic       clk;
   logic       rst_n;
   logic       flush;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [7:0] out_seq;
`ifdef LOGICNETS_STALL_CNT_EN
   logic [15:0] stall_cnt;
   logic        in_ready4, out_valid4;
   logic [7:0]  out_data4, out_seq4;
   logic [3:0]  stall_cnt4;
`endif

   int n_cmp = 0;
   int n_err = 0;

   logic [15:0] mq[$];
   logic [7:0]  mseq;
   int          mstall;
   int          mstall4;

   logicnets_layer_pipe #(.NEURONS(8), .SEQ_W(8), .CNT_W(16)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_seq  (out_seq)
`ifdef LOGICNETS_STALL_CNT_EN
      ,
      .stall_cnt(stall_cnt)
`endif
   );

`ifdef LOGICNETS_STALL_CNT_EN
   logicnets_layer_pipe #(.NEURONS(8), .SEQ_W(8), .CNT_W(4)) u_dut4 (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready4),
      .in_data  (in_data),
      .out_valid(out_valid4),
      .out_ready(out_ready),
      .out_data (out_data4),
      .out_seq  (out_seq4),
      .stall_cnt(stall_cnt4)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      mq.delete();
      mseq    = '0;
      mstall  = 0;
      mstall4 = 0;
   endtask

   // One clock: drive inputs, advance the model at the edge, settle at negedge.
   task automatic step(input logic iv, input logic [7:0] d,
                       input logic ordy, input logic fl);
      bit inf, outf;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      @(posedge clk);
      if (fl) begin
         model_clear();
      end else begin
         inf  = iv && (mq.size() < 2);
         outf = (mq.size() > 0) && ordy;
         if (mq.size() > 0 && !ordy) begin
            if (mstall < 65535) mstall++;
            if (mstall4 < 15) mstall4++;
         end
         if (outf) void'(mq.pop_front());
         if (inf) begin
            mq.push_back({mseq, d});
            mseq = mseq + 8'd1;
         end
      end
      @(negedge clk);
   endtask

   task automatic chk_model(input string tag);
      logic [15:0] h;
      chk({tag, "_valid"}, 32'(out_valid), 32'(mq.size() > 0));
      chk({tag, "_ready"}, 32'(in_ready), 32'(mq.size() < 2));
      if (mq.size() > 0) begin
         h = mq[0];
         chk({tag, "_data"}, 32'(out_data), 32'(h[7:0]));
         chk({tag, "_seq"}, 32'(out_seq), 32'(h[15:8]));
      end
`ifdef LOGICNETS_STALL_CNT_EN
      chk({tag, "_stall"}, 32'(stall_cnt), 32'(mstall));
`endif
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      flush     = 1'b0;
      rst_n     = 1'b0;
      model_clear();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   typedef struct packed {
      logic       iv;
      logic [7:0] d;
      logic       ordy;
      logic       ev;
      logic       er;
      logic [7:0] ed;
      logic [7:0] es;
   } vec_t;

   vec_t tbl[9];

   initial begin
      tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11, 8'h00};
      tbl[1] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'h11, 8'h00};
      tbl[2] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 8'h11, 8'h00};
      tbl[3] = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h22, 8'h01};
      tbl[4] = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h33, 8'h02};
      tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00};
      tbl[6] = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 8'h44, 8'h03};
      tbl[7] = '{1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 8'h55, 8'h04};
      tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00};

      do_reset();
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_ready", 32'(in_ready), 1);
      chk("rst_data", 32'(out_data), 0);
      chk("rst_seq", 32'(out_seq), 0);
`ifdef LOGICNETS_STALL_CNT_EN
      chk("rst_stall", 32'(stall_cnt), 0);
`endif

      // Streaming: one vector per cycle, tags 0..9.
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 8'(8'hA0 + i), 1'b1, 1'b0);
         chk("strm_valid", 32'(out_valid), 1);
         chk("strm_ready", 32'(in_ready), 1);
         chk("strm_data", 32'(out_data), 32'(8'hA0 + i));
         chk("strm_seq", 32'(out_seq), 32'(i));
      end
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk_model("strm_end");

      // Backpressure and simultaneous fire, table driven.
      do_reset();
      for (int i = 0; i < 9; i++) begin
         step(tbl[i].iv, tbl[i].d, tbl[i].ordy, 1'b0);
         chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
         chk($sformatf("tbl%0d_ready", i), 32'(in_ready), 32'(tbl[i].er));
         if (tbl[i].ev) begin
            chk($sformatf("tbl%0d_data", i), 32'(out_data), 32'(tbl[i].ed));
            chk($sformatf("tbl%0d_seq", i), 32'(out_seq), 32'(tbl[i].es));
         end
      end

      // Tag wrap after 257 accepts.
      do_reset();
      for (int i = 0; i < 257; i++) begin
         step(1'b1, 8'($urandom), 1'b1, 1'b0);
         if (i == 255) chk("wrap_seq255", 32'(out_seq), 32'hFF);
      end
      chk("wrap_seq", 32'(out_seq), 0);
      chk_model("wrap");

      // Flush while FULL with input offered.
      step(1'b1, 8'hAA, 1'b0, 1'b0);
      step(1'b1, 8'hBB, 1'b0, 1'b0);
      chk("fl_full", 32'(in_ready), 0);
      step(1'b1, 8'hCC, 1'b0, 1'b1);
      chk("fl_valid", 32'(out_valid), 0);
      chk("fl_ready", 32'(in_ready), 1);
      chk("fl_data", 32'(out_data), 0);
      chk("fl_seq", 32'(out_seq), 0);
      step(1'b1, 8'h77, 1'b1, 1'b0);
      chk("fl_next_data", 32'(out_data), 32'h77);
      chk("fl_next_seq", 32'(out_seq), 0);

`ifdef LOGICNETS_STALL_CNT_EN
      // Stall counting, saturation on the narrow instance.
      do_reset();
      step(1'b1, 8'h5A, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
      chk("stall5", 32'(stall_cnt), 5);
      chk("stall5_n", 32'(stall_cnt4), 5);
      for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
      chk("stall20", 32'(stall_cnt), 20);
      chk("stall20_sat", 32'(stall_cnt4), 15);
`else
      do_reset();
      step(1'b1, 8'h5A, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
`endif

      // Asynchronous reset in the middle of a stall.
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(out_valid), 0);
      chk("arst_ready", 32'(in_ready), 1);
      chk("arst_data", 32'(out_data), 0);
`ifdef LOGICNETS_STALL_CNT_EN
      chk("arst_stall", 32'(stall_cnt), 0);
      chk("arst_stall_n", 32'(stall_cnt4), 0);
`endif
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      step(1'b1, 8'h3C, 1'b0, 1'b0);
      chk("arst_seq", 32'(out_seq), 0);
      chk("arst_dat2", 32'(out_data), 32'h3C);

      // Randomized traffic against the FIFO model.
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 31) == 0));
         chk_model("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
